// File: rtl/vga_frame_engine.sv
// vga_frame_engine: VGA timing, linear frame-buffer addressing and overlay compositing.
// Defining VGA_TESTPAT_EN adds a test_en input that replaces active video with 8 colour bars.
module vga_frame_engine #(
    parameter int H_ACT    = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACT    = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int DATA_LAT = 2,
    parameter int NUM_OVL  = 2,
    parameter int ADDR_W   = 19
) (
    input  logic                    iVGA_CLK,
    input  logic                    iRST_n,
`ifdef VGA_TESTPAT_EN
    input  logic                    test_en,
`endif
    input  logic [23:0]             pix_bgr_in,
    input  logic [NUM_OVL-1:0]      ovl_sel,
    input  logic [24*NUM_OVL-1:0]   ovl_color,
    output logic [ADDR_W-1:0]       oADDR,
    output logic [9:0]              oX,
    output logic [9:0]              oY,
    output logic                    oFRAME_START,
    output logic                    oHS,
    output logic                    oVS,
    output logic                    oBLANK_n,
    output logic [7:0]              b_data,
    output logic [7:0]              g_data,
    output logic [7:0]              r_data
);
    localparam logic [11:0] H_END = 12'(H_SYNC + H_BACK + H_ACT + H_FRONT - 1);
    localparam logic [11:0] V_END = 12'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);
    localparam logic [11:0] H_OFF = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] V_OFF = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] H_LIM = 12'(H_SYNC + H_BACK + H_ACT);
    localparam logic [11:0] V_LIM = 12'(V_SYNC + V_BACK + V_ACT);
    localparam logic [11:0] HS_W  = 12'(H_SYNC);
    localparam logic [11:0] VS_W  = 12'(V_SYNC);
    localparam logic        HSP   = 1'(HS_POL);
    localparam logic        VSP   = 1'(VS_POL);

    logic [11:0] h, v, hx, vy;
    logic        hs_a, vs_a, act, fs;
    logic [2:0]  sp [0:DATA_LAT];
    logic [23:0] ovl_pix, col;

    always_comb begin
        hs_a = h < HS_W;
        vs_a = v < VS_W;
        act  = (h >= H_OFF) && (h < H_LIM) && (v >= V_OFF) && (v < V_LIM);
        fs   = (h == '0) && (v == '0);
        hx   = h - H_OFF;
        vy   = v - V_OFF;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= (h == H_END) ? '0 : h + 12'd1;
            if (h == H_END) v <= (v == V_END) ? '0 : v + 12'd1;
        end
    end

    // Stage 0: address and coordinates stay aligned with the pixel being fetched
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oADDR        <= '0;
            oX           <= '0;
            oY           <= '0;
            oFRAME_START <= 1'b0;
        end else begin
            oFRAME_START <= fs;
            if (fs) oADDR <= '0;
            else if (act) oADDR <= (h == H_OFF && v == V_OFF) ? '0 : oADDR + ADDR_W'(1);
            if (act) begin
                oX <= hx[9:0];
                oY <= vy[9:0];
            end
        end
    end

    // {hsync, vsync, active} delayed to meet the memory data at stage DATA_LAT
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sp <= '{default: '0};
        end else begin
            sp[0] <= {hs_a, vs_a, act};
            for (int i = 1; i <= DATA_LAT; i++) sp[i] <= sp[i-1];
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                        24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
    logic [9:0] xd [1:DATA_LAT];
    logic [2:0] bar;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            xd <= '{default: '0};
        end else begin
            xd[1] <= oX;
            for (int i = 2; i <= DATA_LAT; i++) xd[i] <= xd[i-1];
        end
    end

    assign bar = 3'((32'(xd[DATA_LAT]) * 8) / H_ACT);
`endif

    // Lowest set overlay index wins, so scan from the top down
    always_comb begin
        ovl_pix = pix_bgr_in;
        for (int k = NUM_OVL - 1; k >= 0; k--)
            if (ovl_sel[k]) ovl_pix = ovl_color[24*k +: 24];
`ifdef VGA_TESTPAT_EN
        col = test_en ? BARS[bar] : ovl_pix;
`else
        col = ovl_pix;
`endif
        if (!sp[DATA_LAT][0]) col = '0;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHS                      <= ~HSP;
            oVS                      <= ~VSP;
            oBLANK_n                 <= 1'b0;
            {b_data, g_data, r_data} <= '0;
        end else begin
            oHS                      <= sp[DATA_LAT][2] ? HSP : ~HSP;
            oVS                      <= sp[DATA_LAT][1] ? VSP : ~VSP;
            oBLANK_n                 <= sp[DATA_LAT][0];
            {b_data, g_data, r_data} <= col;
        end
    end
endmodule

// File: tb/tb_vga_frame_engine.sv
// tb_vga_frame_engine: small-timing bench with a reference timing model, a ROM model
// and a queue of expected pin values compared DATA_LAT+1 clocks after each address.
module tb_vga_frame_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] pix = '0;
    logic [1:0]  sel = '0;
    logic [47:0] ocol = {24'h00FF00, 24'hFF0000};
`ifdef VGA_TESTPAT_EN
    logic        test_en = 1'b0;
`endif
    logic [18:0] oADDR;
    logic [9:0]  oX, oY;
    logic        oFRAME_START, oHS, oVS, oBLANK_n;
    logic [7:0]  b_data, g_data, r_data;

    vga_frame_engine #(
        .H_ACT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACT(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(0), .VS_POL(0), .DATA_LAT(2), .NUM_OVL(2), .ADDR_W(19)
    ) dut (
        .iVGA_CLK(clk),
        .iRST_n(rst_n),
`ifdef VGA_TESTPAT_EN
        .test_en(test_en),
`endif
        .pix_bgr_in(pix),
        .ovl_sel(sel),
        .ovl_color(ocol),
        .oADDR(oADDR),
        .oX(oX),
        .oY(oY),
        .oFRAME_START(oFRAME_START),
        .oHS(oHS),
        .oVS(oVS),
        .oBLANK_n(oBLANK_n),
        .b_data(b_data),
        .g_data(g_data),
        .r_data(r_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic hs; logic vs; logic bl; logic [23:0] col; } pin_t;
    typedef struct packed { logic [7:0] a; logic [1:0] sel; logic te; } drv_t;
    typedef struct { logic [1:0] sel; logic use_pix; logic [23:0] col; } vec_t;

    vec_t        vec [4];
    logic [23:0] bars [8];
    pin_t        exp_q [$];
    drv_t        drv_q [$];
    int          n_tests = 0, n_fail = 0;
    int          k, ma, mx, my, cnt_hs, cnt_vs, cnt_bl;
    logic        tp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic restart();
        k = 0; ma = 0; mx = 0; my = 0;
        cnt_hs = 0; cnt_vs = 0; cnt_bl = 0;
        exp_q.delete();
        drv_q.delete();
        repeat (3) exp_q.push_back('{1'b1, 1'b1, 1'b0, 24'h0});
        pix = '0;
        sel = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, oADDR, 0);
        chk({tag, "_x"}, oX, 0);
        chk({tag, "_y"}, oY, 0);
        chk({tag, "_fs"}, oFRAME_START, 0);
        chk({tag, "_hs"}, oHS, 1);
        chk({tag, "_vs"}, oVS, 1);
        chk({tag, "_blank_n"}, oBLANK_n, 0);
        chk({tag, "_rgb"}, {b_data, g_data, r_data}, 0);
    endtask

    // One clock: check stage-0 outputs against the model, drive ROM data, score the pins
    task automatic step();
        int h, v;
        logic act;
        logic [7:0] a;
        pin_t e, p;
        drv_t d;
        vec_t t;
        @(negedge clk);
        k++;
        h = (k - 1) % 15;
        v = ((k - 1) / 15) % 8;
        act = h >= 5 && h < 13 && v >= 3 && v < 7;
        if (h == 0 && v == 0) ma = 0;
        if (act) begin
            ma = (v - 3) * 8 + (h - 5);
            mx = h - 5;
            my = v - 3;
        end
        chk("frame_start", oFRAME_START, {31'b0, h == 0 && v == 0});
        chk("addr", oADDR, ma);
        chk("x", oX, mx);
        chk("y", oY, my);
        t = vec[k % 4];
        a = 8'(ma);
        e.hs = !(h < 3);
        e.vs = !(v < 2);
        e.bl = act;
        e.col = !act ? 24'h0 : tp ? bars[mx] : t.use_pix ? {3{a}} : t.col;
        exp_q.push_back(e);
        drv_q.push_back('{a, t.sel, tp});
        if (drv_q.size() == 3) begin
            d = drv_q.pop_front();
            pix = {3{d.a}};
            sel = d.sel;
`ifdef VGA_TESTPAT_EN
            test_en = d.te;
`endif
        end
        p = exp_q.pop_front();
        chk("hs", oHS, p.hs);
        chk("vs", oVS, p.vs);
        chk("blank_n", oBLANK_n, p.bl);
        chk("rgb", {b_data, g_data, r_data}, p.col);
        if (k >= 4 && k <= 123) begin
            cnt_hs += int'(!oHS);
            cnt_vs += int'(!oVS);
            cnt_bl += int'(oBLANK_n);
        end
    endtask

    initial begin
        vec[0] = '{2'b11, 1'b0, 24'hFF0000};
        vec[1] = '{2'b10, 1'b0, 24'h00FF00};
        vec[2] = '{2'b00, 1'b1, 24'h000000};
        vec[3] = '{2'b01, 1'b0, 24'hFF0000};
        bars = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                 24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
        restart();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (360) step();
        chk("hs_low_per_frame", cnt_hs, 24);
        chk("vs_low_per_frame", cnt_vs, 30);
        chk("blank_high_per_frame", cnt_bl, 32);

        while ((k - 1) % 120 != 67) step();
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        repeat (2) @(negedge clk);
        check_reset("held_reset");
        restart();
        rst_n = 1'b1;
        repeat (240) step();
        chk("restart_hs_low", cnt_hs, 24);
        chk("restart_vs_low", cnt_vs, 30);
        chk("restart_blank_high", cnt_bl, 32);
`ifdef VGA_TESTPAT_EN
        tp = 1'b1;
        repeat (240) step();
        tp = 1'b0;
        repeat (10) step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
